// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared FSM state type, default geometry and clog2 helper for the fetch block
package checker_pkg;

  localparam int NBANKS_DEF = 8;
  localparam int IBYTES_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/checker_byte_rotate.sv
// rtl/checker_byte_rotate.sv - combinational rotation of bank read bytes into instruction byte order
module checker_byte_rotate
  import checker_pkg::*;
#(
  parameter  int NBANKS = NBANKS_DEF,
  parameter  int IBYTES = IBYTES_DEF,
  localparam int LW     = clog2(NBANKS)
) (
  input  logic [NBANKS*8-1:0] i_banks,
  input  logic [LW-1:0]       i_offset,
  output logic [IBYTES*8-1:0] o_data
);

  logic [LW-1:0] w_idx;

  // Output byte j comes from bank (offset + j); the LW-bit sum wraps mod NBANKS
  always_comb begin
    o_data = '0;
    w_idx  = '0;
    for (int j = 0; j < IBYTES; j++) begin
      w_idx = i_offset + LW'(j);
      o_data[j*8 +: 8] = i_banks[w_idx*8 +: 8];
    end
  end

endmodule

// File: rtl/checker_mpu_fetch.sv
// rtl/checker_mpu_fetch.sv - unaligned instruction fetch over byte-wide RAM banks; optional last-fetch buffer via CHECKER_MPU_FETCH_LAST_HIT_EN
module checker_mpu_fetch
  import checker_pkg::*;
#(
  parameter  int NBANKS = NBANKS_DEF,
  parameter  int IBYTES = IBYTES_DEF,
  parameter  int AW     = 15,
  localparam int LW     = clog2(NBANKS),
  localparam int BAW    = AW - LW
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  i_stb_i,
  input  logic [AW-1:0]         i_addr_i,
  output logic                  i_rdy_o,
  output logic [8*IBYTES-1:0]   i_data_o,
  output logic                  i_valid_o,
  input  logic                  i_ready_i,
  input  logic                  inv_i,
  output logic                  ram_en_o,
  output logic [NBANKS*BAW-1:0] ram_adr_o,
  input  logic [NBANKS*8-1:0]   ram_dat_i
);

  state_t              r_state;
  state_t              w_next;
  logic [LW-1:0]       r_offset;
  logic [8*IBYTES-1:0] r_data;
  logic [8*IBYTES-1:0] w_rot;
  logic [8*IBYTES-1:0] w_hit_data;
  logic [AW-1:0]       w_sum;
  logic                w_rdy;
  logic                w_accept;
  logic                w_hit;

  assign w_rdy    = (r_state == IDLE) | ((r_state == VALID) & i_ready_i);
  assign w_accept = i_stb_i & w_rdy;

`ifdef CHECKER_MPU_FETCH_LAST_HIT_EN
  logic [AW-1:0]       r_req_addr;
  logic [AW-1:0]       r_last_addr;
  logic [8*IBYTES-1:0] r_last_data;
  logic                r_last_valid;

  // A write seen this cycle makes the buffer stale, so it also vetoes a hit
  assign w_hit      = r_last_valid & ~inv_i & (i_addr_i == r_last_addr);
  assign w_hit_data = r_last_data;

  // Capture the requested address, and remember what was actually handed over
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_req_addr   <= '0;
      r_last_addr  <= '0;
      r_last_data  <= '0;
      r_last_valid <= 1'b0;
    end else begin
      if (w_accept) r_req_addr <= i_addr_i;
      if (inv_i) begin
        r_last_valid <= 1'b0;
      end else if ((r_state == VALID) & i_ready_i) begin
        r_last_valid <= 1'b1;
        r_last_addr  <= r_req_addr;
        r_last_data  <= r_data;
      end
    end
  end
`else
  logic w_unused_inv;

  assign w_unused_inv = inv_i;
  assign w_hit        = 1'b0;
  assign w_hit_data   = '0;
`endif

  checker_byte_rotate #(
    .NBANKS (NBANKS),
    .IBYTES (IBYTES)
  ) u_rotate (
    .i_banks  (ram_dat_i),
    .i_offset (r_offset),
    .o_data   (w_rot)
  );

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next-state: a hit skips the RAM cycle and goes straight to VALID
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_hit ? VALID : READ;
      READ:    w_next = VALID;
      VALID:   if (i_ready_i) begin
                 if (i_stb_i) w_next = w_hit ? VALID : READ;
                 else         w_next = IDLE;
               end
      default: w_next = IDLE;
    endcase
  end

  // Outputs: handshake flags and per-bank row addresses for the accepted request
  always_comb begin
    i_rdy_o   = w_rdy;
    i_valid_o = (r_state == VALID);
    i_data_o  = r_data;
    ram_en_o  = w_accept & ~w_hit & sys_rst_n;
    ram_adr_o = '0;
    w_sum     = '0;
    for (int k = 0; k < NBANKS; k++) begin
      w_sum = i_addr_i + AW'(NBANKS - 1 - k);
      ram_adr_o[k*BAW +: BAW] = w_sum[AW-1:LW];
    end
  end

  // Datapath: offset for the rotation stage, instruction register loaded in READ or on a hit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_offset <= '0;
      r_data   <= '0;
    end else begin
      if (w_accept) r_offset <= i_addr_i[LW-1:0];
      if (r_state == READ)       r_data <= w_rot;
      else if (w_accept & w_hit) r_data <= w_hit_data;
    end
  end

endmodule

// File: tb/tb_checker_mpu_fetch.sv
// tb/tb_checker_mpu_fetch.sv - table-driven scoreboard bench for checker_mpu_fetch
module tb_checker_mpu_fetch;

  localparam int NB  = 8;
  localparam int IB  = 6;
  localparam int AW  = 15;
  localparam int BAW = 12;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              i_stb_i   = 1'b0;
  logic              i_ready_i = 1'b1;
  logic              inv_i     = 1'b0;
  logic [AW-1:0]     i_addr_i  = '0;
  logic [NB*8-1:0]   ram_dat_i = '0;
  logic              i_rdy_o;
  logic              i_valid_o;
  logic              ram_en_o;
  logic [8*IB-1:0]   i_data_o;
  logic [NB*BAW-1:0] ram_adr_o;

  checker_mpu_fetch dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_stb_i   (i_stb_i),
    .i_addr_i  (i_addr_i),
    .i_rdy_o   (i_rdy_o),
    .i_data_o  (i_data_o),
    .i_valid_o (i_valid_o),
    .i_ready_i (i_ready_i),
    .inv_i     (inv_i),
    .ram_en_o  (ram_en_o),
    .ram_adr_o (ram_adr_o),
    .ram_dat_i (ram_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous banked RAM preloaded with bank k row r = (8r+k) & 0xFF
  always @(posedge sys_clk) begin
    if (ram_en_o)
      for (int k = 0; k < NB; k++)
        ram_dat_i[k*8 +: 8] <= 8'((32'(ram_adr_o[k*BAW +: BAW]) << 3) + k);
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string msg);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  // Instruction bytes at A.. are simply consecutive byte addresses, low 8 bits
  function automatic logic [8*IB-1:0] model(input logic [AW-1:0] a);
    logic [8*IB-1:0] d;
    logic [AW-1:0]   b;
    d = '0;
    for (int j = 0; j < IB; j++) begin
      b = a + AW'(j);
      d[j*8 +: 8] = b[7:0];
    end
    return d;
  endfunction

  // Each of the NB consecutive bytes from A lives in its own bank at row byte>>3
  function automatic logic [NB*BAW-1:0] rows(input logic [AW-1:0] a);
    logic [NB*BAW-1:0] r;
    logic [AW-1:0]     b;
    r = '0;
    for (int j = 0; j < NB; j++) begin
      b = a + AW'(j);
      r[b[2:0]*BAW +: BAW] = b[AW-1:3];
    end
    return r;
  endfunction

  typedef struct {
    logic [8*IB-1:0] d;
    int              acc;
    int              lat;
  } sb_t;

  sb_t             q[$];
  logic [8*IB-1:0] exp_next = '0;
  bit              exp_hit  = 1'b0;
  bit              seen     = 1'b0;
  logic [8*IB-1:0] held     = '0;

  // Monitor: pop on first valid cycle, check hold while stalled, push on accept
  always @(negedge sys_clk) begin
    sb_t e;
    if (!sys_rst_n) begin
      seen = 1'b0;
    end else begin
      if (i_valid_o) begin
        if (!seen) begin
          if (q.size() == 0) begin
            fail_now("spurious_valid: i_valid_o=1 with nothing outstanding");
          end else begin
            e = q.pop_front();
            check("data", i_data_o, e.d);
            check("latency", cyc - e.acc, e.lat);
            held = e.d;
          end
          seen = 1'b1;
        end else begin
          check("hold", i_data_o, held);
        end
        if (i_ready_i) seen = 1'b0;
      end else begin
        seen = 1'b0;
      end
      if (i_stb_i && i_rdy_o) begin
        check("ram_en_accept", ram_en_o, !exp_hit);
        if (!exp_hit) check("ram_adr", ram_adr_o, rows(i_addr_i));
        e.d   = exp_next;
        e.acc = cyc;
        e.lat = exp_hit ? 1 : 2;
        q.push_back(e);
      end else begin
        check("ram_en_idle", ram_en_o, 1'b0);
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic [8*IB-1:0] e, input bit hit);
    int t;
    t        = 0;
    exp_next = e;
    exp_hit  = hit;
    i_addr_i = a;
    i_stb_i  = 1'b1;
    do begin
      @(negedge sys_clk);
      t++;
    end while (!i_rdy_o && t < 100);
    if (!i_rdy_o) fail_now("timeout waiting for i_rdy_o");
    @(posedge sys_clk);
    #1;
    i_stb_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || i_valid_o) && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    if (q.size() != 0 || i_valid_o) fail_now("timeout waiting for delivery");
    @(posedge sys_clk);
    #1;
  endtask

  typedef struct {
    logic [AW-1:0]   addr;
    logic [8*IB-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            nv;
    int            t;

    tbl[0] = '{15'h0000, 48'h050403020100};
    tbl[1] = '{15'h0003, 48'h080706050403};
    tbl[2] = '{15'h7FFD, 48'h020100FFFEFD};
    tbl[3] = '{15'h1234, 48'h393837363534};
    tbl[4] = '{15'h00FE, 48'h03020100FFFE};
    tbl[5] = '{15'h7FF8, 48'hFDFCFBFAF9F8};

    #12;
    check("rst_valid", i_valid_o, 1'b0);
    check("rst_data", i_data_o, '0);
    check("rst_ram_en", ram_en_o, 1'b0);
    check("rst_rdy", i_rdy_o, 1'b1);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Table vectors, one at a time; first one is accepted on the first edge after release
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].addr, tbl[i].exp, 1'b0);
      wait_idle();
    end
    check("idle_retain", i_data_o, tbl[5].exp);

    // Back-to-back stream: latency check on each enforces one per 2 cycles
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom);
      issue(a, model(a), 1'b0);
    end
    wait_idle();

    // Stall three cycles in VALID with a request pending, then release
    i_ready_i = 1'b0;
    issue(15'h0040, model(15'h0040), 1'b0);
    exp_next = model(15'h0123);
    exp_hit  = 1'b0;
    i_addr_i = 15'h0123;
    i_stb_i  = 1'b1;
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (!i_valid_o && t < 20);
    if (!i_valid_o) fail_now("timeout waiting for stalled valid");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge sys_clk);
      check("stall_rdy", i_rdy_o, 1'b0);
    end
    @(posedge sys_clk);
    #1;
    i_ready_i = 1'b1;
    @(negedge sys_clk);
    check("stall_release_rdy", i_rdy_o, 1'b1);
    @(posedge sys_clk);
    #1;
    i_stb_i = 1'b0;
    wait_idle();

    // Reset while in READ discards the fetch
    issue(15'h0200, model(15'h0200), 1'b0);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("rstread_valid", i_valid_o, 1'b0);
    check("rstread_data", i_data_o, '0);
    check("rstread_ram_en", ram_en_o, 1'b0);
    q.delete();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (i_valid_o) nv++;
    end
    check("rstread_no_output", nv, 0);
    @(posedge sys_clk);
    #1;

`ifdef CHECKER_MPU_FETCH_LAST_HIT_EN
    issue(15'h0010, model(15'h0010), 1'b0);
    wait_idle();
    issue(15'h0010, model(15'h0010), 1'b1);
    wait_idle();
    inv_i = 1'b1;
    @(posedge sys_clk);
    #1;
    inv_i = 1'b0;
    issue(15'h0010, model(15'h0010), 1'b0);
    wait_idle();
    inv_i = 1'b1;
    issue(15'h0010, model(15'h0010), 1'b0);
    inv_i = 1'b0;
    wait_idle();
    issue(15'h0011, model(15'h0011), 1'b0);
    wait_idle();
`else
    issue(15'h0010, model(15'h0010), 1'b0);
    wait_idle();
    inv_i = 1'b1;
    issue(15'h0010, model(15'h0010), 1'b0);
    inv_i = 1'b0;
    wait_idle();
    issue(15'h0010, model(15'h0010), 1'b0);
    wait_idle();
`endif

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/checker_mpu_fetch.md
CHECKER_MPU_FETCH -- requirements
Module: checker_mpu_fetch

Interface
REQ-001 Parameter NBANKS, default 8, means the number of byte-wide RAM banks; it SHALL be a power of two, 2..16.
REQ-002 Parameter IBYTES, default 6, means instruction width in bytes; it SHALL satisfy 1 <= IBYTES <= NBANKS.
REQ-003 Parameter AW, default 15, means the width of the byte address; localparam BAW = AW - log2(NBANKS) is the bank row address width.
REQ-004 sys_clk  in  1  means the single clock; all state SHALL be on its rising edge.
REQ-005 sys_rst_n  in  1  means the asynchronous, active-low reset.
REQ-006 i_stb_i  in  1  means the fetch request strobe.
REQ-007 i_addr_i  in  AW  means the byte address of the instruction, sampled on accept.
REQ-008 i_rdy_o  out  1  means the block can accept a request this cycle.
REQ-009 i_data_o  out  8*IBYTES  means the fetched instruction; byte at i_addr_i is in [7:0], ascending.
REQ-010 i_valid_o  out  1  means i_data_o is valid.
REQ-011 i_ready_i  in  1  means the consumer takes i_data_o this cycle.
REQ-012 inv_i  in  1  means the last-fetch buffer is invalidated (RAM was written).
REQ-013 ram_en_o  out  1  means read enable to all banks.
REQ-014 ram_adr_o  out  NBANKS*BAW  means row address per bank; bank k is in slice [k*BAW +: BAW].
REQ-015 ram_dat_i  in  NBANKS*8  means read data per bank, returned one cycle after ram_en_o (synchronous RAM).

Function
REQ-016 Byte address A SHALL map to bank A mod NBANKS, row A >> log2(NBANKS).
REQ-017 The accept condition SHALL be i_stb_i & i_rdy_o, and i_rdy_o = (state==IDLE) | (state==VALID & i_ready_i).
REQ-018 On accept, ram_en_o SHALL be 1 that cycle, with bank k row = ((i_addr_i + NBANKS-1-k) >> log2(NBANKS)) truncated to BAW bits (wraps at top of memory).
REQ-019 When not accepting, ram_en_o SHALL be 0; ram_adr_o is don't-care.
REQ-020 On accept, the offset i_addr_i mod NBANKS SHALL be registered for the rotation stage.
REQ-021 The FSM SHALL have the states IDLE, READ and VALID: IDLE --accept--> READ; READ --> VALID unconditionally; VALID --i_ready_i & accept--> READ; VALID --i_ready_i & !i_stb_i--> IDLE; VALID --!i_ready_i--> VALID.
REQ-022 In READ, i_data_o SHALL be registered as output byte j = bank (offset+j) mod NBANKS data, for j = 0..IBYTES-1.
REQ-023 i_valid_o SHALL be 1 exactly in VALID; latency SHALL be 2 cycles from accept to i_valid_o.
REQ-024 Sustained throughput SHALL be one instruction per 2 cycles with i_ready_i held at 1.
REQ-025 While i_valid_o & !i_ready_i, i_data_o SHALL hold and no request is accepted.
REQ-026 i_data_o SHALL retain its last value in IDLE.

Reset
REQ-027 Asserting sys_rst_n low SHALL immediately force state IDLE, i_valid_o 0, i_data_o 0, ram_en_o 0, offset 0 and last-fetch valid 0, including mid-READ; the in-flight fetch is discarded.
REQ-028 After release, the first rising edge SHALL be able to accept a request.

Configuration
REQ-029 With CHECKER_MPU_FETCH_LAST_HIT_EN defined, the block SHALL store the last delivered address and instruction; an accept whose address equals it while the buffer is valid SHALL keep ram_en_o 0, go straight to VALID, and assert i_valid_o 1 cycle after accept.
REQ-030 inv_i SHALL clear buffer validity in the same edge; inv_i coincident with a hitting accept SHALL force a miss.
REQ-031 Without the macro, inv_i SHALL be ignored and every fetch SHALL take the RAM path.

Structure
REQ-032 Package checker_pkg SHALL hold the FSM state enum and a clog2 function; NBANKS/IBYTES defaults belong there.
REQ-033 The rotation network SHALL be the sub-module checker_byte_rotate (parameters NBANKS, IBYTES; purely combinational).

Verification
Memory preload: bank k row r = (8r+k) & 0xFF; defaults NBANKS=8, IBYTES=6, AW=15.
REQ-034 Accept addr 0x0000, i_ready_i=1 -> i_valid_o 2 cycles later, i_data_o=0x050403020100.
REQ-035 Addr 0x0003 -> bank0 row 1, bank7 row 0; i_data_o=0x080706050403.
REQ-036 Wrap: addr 0x7FFD -> bank0 row 0x000; i_data_o=0x020100FFFEFD.
REQ-037 Stall: i_ready_i=0 for 3 cycles in VALID -> data held, i_rdy_o=0; then a back-to-back accept when i_ready_i rises -> next i_valid_o 2 cycles later.
REQ-038 sys_rst_n low in READ -> i_valid_o 0 immediately, no output follows release.
REQ-039 With the macro: addr 0x0010 twice -> 2nd has ram_en_o=0 and latency 1; with inv_i pulsed between -> 2nd has ram_en_o=1 and latency 2.
